// File: rtl/draw_arb_pkg.sv
// Shared definitions for the draw request arbiter.
// Holds the requester index map, the arbiter state encoding and the default
// maze grid coordinate width.
package draw_arb_pkg;

  // Requester indices; a lower index wins arbitration.
  localparam int unsigned REQ_CLEAR   = 0;
  localparam int unsigned REQ_MAZE    = 1;
  localparam int unsigned REQ_ERASE   = 2;
  localparam int unsigned REQ_SPECIAL = 3;
  localparam int unsigned REQ_DRAW    = 4;
  localparam int unsigned REQ_START   = 5;

  // Width of one maze grid X or Y coordinate.
  localparam int unsigned COORD_W = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/draw_request_arbiter_picker.sv
// Combinational fixed-priority picker: the lowest set bit of the pending
// vector wins.
// Ports:
//   pending_i  requests waiting for service, one bit per requester
//   grant_o    one-hot grant (all zero when nothing is pending)
//   idx_o      binary index of the granted requester (0 when nothing pending)
module fixed_priority_picker #(
  parameter int unsigned NUM_REQ = 6,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] pending_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_request_arbiter.sv
// Shares the single pixel-draw engine among the game's draw requesters.
// One-cycle requests are latched with their coordinates, granted one at a
// time by fixed priority, launched with a start pulse, and acknowledged with
// a per-requester done pulse once the engine reports completion.
// Ports:
//   clock, reset       system clock; asynchronous active-high reset
//   req, req_x, req_y  request strobes and flattened per-requester coordinates
//   engine_done        completion pulse from the draw engine
//   engine_start       one-cycle launch pulse to the engine
//   engine_op          index of the granted requester
//   engine_x/engine_y  coordinates of the granted operation
//   done               one-cycle completion pulse per requester
//   busy               high while an operation is issued or in flight
//   timeout_err        one-cycle pulse when an operation is aborted
module draw_request_arbiter #(
  parameter int unsigned NUM_REQ        = 6,
  parameter int unsigned COORD_W        = draw_arb_pkg::COORD_W,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned TO_W           = 21
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic                       engine_done,
  output logic                       engine_start,
  output logic [2:0]                 engine_op,
  output logic [COORD_W-1:0]         engine_x,
  output logic [COORD_W-1:0]         engine_y,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       timeout_err
);

  import draw_arb_pkg::*;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [COORD_W-1:0]   slot_x_q [NUM_REQ];
  logic [COORD_W-1:0]   slot_x_d [NUM_REQ];
  logic [COORD_W-1:0]   slot_y_q [NUM_REQ];
  logic [COORD_W-1:0]   slot_y_d [NUM_REQ];
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 start_q, start_d;
  logic [2:0]           op_q, op_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [2:0]           grant_idx;

  fixed_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (3)
  ) u_picker (
    .pending_i (pending_q),
    .grant_o   (grant_oh),
    .idx_o     (grant_idx)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    op_d      = op_q;
    x_d       = x_q;
    y_d       = y_q;
    done_d    = '0;
    busy_d    = busy_q;
    terr_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|grant_oh) begin
          op_d    = grant_idx;
          x_d     = slot_x_q[grant_idx];
          y_d     = slot_y_q[grant_idx];
          start_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (engine_done) begin
          pending_d[op_q] = 1'b0;
          done_d[op_q]    = 1'b1;
          busy_d          = 1'b0;
          state_d         = StIdle;
        end else if (cnt_q == TO_LAST) begin
          pending_d[op_q] = 1'b0;
          terr_d          = 1'b1;
          busy_d          = 1'b0;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture is applied after the completion clear so a request arriving on
    // the same edge survives and the index is served again later.
    pending_d = pending_d | req;
    slot_x_d  = slot_x_q;
    slot_y_d  = slot_y_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        slot_x_d[i] = req_x[i*COORD_W +: COORD_W];
        slot_y_d[i] = req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pending_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_x_q[i] <= '0;
        slot_y_q[i] <= '0;
      end
      cnt_q     <= '0;
      start_q   <= 1'b0;
      op_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      slot_x_q  <= slot_x_d;
      slot_y_q  <= slot_y_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      op_q      <= op_d;
      x_q       <= x_d;
      y_q       <= y_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  assign engine_start = start_q;
  assign engine_op    = op_q;
  assign engine_x     = x_q;
  assign engine_y     = y_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// Self-checking bench for draw_request_arbiter: a table of single-request
// transactions plus hand-written sequences for priority, coalescing,
// set/clear collision, timeout and reset mid-operation.
module tb_draw_request_arbiter;

  localparam int unsigned N   = 6;
  localparam int unsigned CW  = 5;
  localparam int unsigned TO  = 16;
  localparam int unsigned TOW = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*CW-1:0]   req_x = '0;
  logic [N*CW-1:0]   req_y = '0;
  logic              engine_done = 1'b0;
  logic              engine_start;
  logic [2:0]        engine_op;
  logic [CW-1:0]     engine_x;
  logic [CW-1:0]     engine_y;
  logic [N-1:0]      done;
  logic              busy;
  logic              timeout_err;

  always #5 clock = ~clock;

  draw_request_arbiter #(
    .NUM_REQ        (N),
    .COORD_W        (CW),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (TOW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .engine_done  (engine_done),
    .engine_start (engine_start),
    .engine_op    (engine_op),
    .engine_x     (engine_x),
    .engine_y     (engine_y),
    .done         (done),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  int tests  = 0;
  int failed = 0;

  // Event logs written only by the monitor; the stimulus reads them relative
  // to base indices it snapshots.
  int op_log   [64];
  int x_log    [64];
  int y_log    [64];
  int done_log [64];
  int n_start = 0;
  int n_done  = 0;
  int n_terr  = 0;

  always @(negedge clock) begin
    if (engine_start === 1'b1) begin
      if (n_start < 64) begin
        op_log[n_start] = int'(engine_op);
        x_log[n_start]  = int'(engine_x);
        y_log[n_start]  = int'(engine_y);
      end
      n_start++;
    end
    for (int i = 0; i < N; i++) begin
      if (done[i] === 1'b1) begin
        if (n_done < 64) done_log[n_done] = i;
        n_done++;
      end
    end
    if (timeout_err === 1'b1) n_terr++;
  end

  function automatic int op_at(input int k);
    return (k >= 0 && k < 64 && k < n_start) ? op_log[k] : -1;
  endfunction
  function automatic int x_at(input int k);
    return (k >= 0 && k < 64 && k < n_start) ? x_log[k] : -1;
  endfunction
  function automatic int y_at(input int k);
    return (k >= 0 && k < 64 && k < n_start) ? y_log[k] : -1;
  endfunction
  function automatic int done_at(input int k);
    return (k >= 0 && k < 64 && k < n_done) ? done_log[k] : -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All stimulus runs just after a falling edge; the monitor has already
  // sampled that edge by the time the stimulus reads the logs.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int idx, input int x, input int y);
    req[idx]               = 1'b1;
    req_x[idx*CW +: CW]    = CW'(x);
    req_y[idx*CW +: CW]    = CW'(y);
  endtask

  task automatic pulse_req(input int idx, input int x, input int y);
    set_req(idx, x, y);
    step();
    req = '0;
  endtask

  task automatic wait_start(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (engine_start === 1'b1) ok = 1'b1;
      else step();
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  // Waits for a grant, then answers with engine_done after dly extra cycles.
  task automatic serve(input string name, input int dly);
    wait_start(name);
    step();
    repeat (dly) step();
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
  endtask

  typedef struct packed {
    logic [2:0]   idx;
    logic [4:0]   x;
    logic [4:0]   y;
    logic [3:0]   dly;
    logic [2:0]   exp_op;
    logic [4:0]   exp_x;
    logic [4:0]   exp_y;
    logic [N-1:0] exp_done;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int bs, bd, bt, lat, errs;

    vecs[0] = '{idx: 3'd4, x: 5'd3,  y: 5'd7,  dly: 4'd10, exp_op: 3'd4, exp_x: 5'd3,
                exp_y: 5'd7,  exp_done: 6'b010000};
    vecs[1] = '{idx: 3'd0, x: 5'd31, y: 5'd0,  dly: 4'd0,  exp_op: 3'd0, exp_x: 5'd31,
                exp_y: 5'd0,  exp_done: 6'b000001};
    vecs[2] = '{idx: 3'd5, x: 5'd0,  y: 5'd31, dly: 4'd3,  exp_op: 3'd5, exp_x: 5'd0,
                exp_y: 5'd31, exp_done: 6'b100000};
    vecs[3] = '{idx: 3'd1, x: 5'd17, y: 5'd9,  dly: 4'd1,  exp_op: 3'd1, exp_x: 5'd17,
                exp_y: 5'd9,  exp_done: 6'b000010};
    vecs[4] = '{idx: 3'd2, x: 5'd12, y: 5'd25, dly: 4'd5,  exp_op: 3'd2, exp_x: 5'd12,
                exp_y: 5'd25, exp_done: 6'b000100};
    vecs[5] = '{idx: 3'd3, x: 5'd30, y: 5'd1,  dly: 4'd2,  exp_op: 3'd3, exp_x: 5'd30,
                exp_y: 5'd1,  exp_done: 6'b001000};

    // Reset state.
    step();
    step();
    chk("rst engine_start", {31'd0, engine_start}, 0);
    chk("rst done",         {26'd0, done}, 0);
    chk("rst busy",         {31'd0, busy}, 0);
    chk("rst timeout_err",  {31'd0, timeout_err}, 0);
    chk("rst engine_op",    {29'd0, engine_op}, 0);
    chk("rst engine_x",     {27'd0, engine_x}, 0);
    chk("rst engine_y",     {27'd0, engine_y}, 0);
    reset = 1'b0;
    step();

    // Single-request transactions with exact latency.
    for (int v = 0; v < 6; v++) begin
      bs = n_start;
      bd = n_done;
      pulse_req(int'(vecs[v].idx), int'(vecs[v].x), int'(vecs[v].y));
      step();
      chk("tbl start",  {31'd0, engine_start}, 1);
      chk("tbl op",     {29'd0, engine_op}, {29'd0, vecs[v].exp_op});
      chk("tbl x",      {27'd0, engine_x}, {27'd0, vecs[v].exp_x});
      chk("tbl y",      {27'd0, engine_y}, {27'd0, vecs[v].exp_y});
      chk("tbl busy",   {31'd0, busy}, 1);
      step();
      repeat (int'(vecs[v].dly)) step();
      chk("tbl x held", {27'd0, engine_x}, {27'd0, vecs[v].exp_x});
      chk("tbl start1", {31'd0, engine_start}, 0);
      engine_done = 1'b1;
      step();
      engine_done = 1'b0;
      chk("tbl done",   {26'd0, done}, {26'd0, vecs[v].exp_done});
      chk("tbl busy0",  {31'd0, busy}, 0);
      step();
      chk("tbl done1",  {26'd0, done}, 0);
      repeat (3) step();
      chk("tbl nstart", n_start - bs, 1);
      chk("tbl ndone",  n_done - bd, 1);
    end

    // Priority: erase (2) before draw (4) when both arrive together.
    bs = n_start;
    bd = n_done;
    set_req(4, 5, 5);
    set_req(2, 4, 5);
    step();
    req = '0;
    serve("prio grant a", 2);
    serve("prio grant b", 2);
    repeat (4) step();
    chk("prio op0",   op_at(bs), 2);
    chk("prio x0",    x_at(bs), 4);
    chk("prio op1",   op_at(bs + 1), 4);
    chk("prio x1",    x_at(bs + 1), 5);
    chk("prio done0", done_at(bd), 2);
    chk("prio done1", done_at(bd + 1), 4);
    chk("prio nst",   n_start - bs, 2);

    // Coalescing: two draw requests while maze is in flight give one grant.
    bs = n_start;
    bd = n_done;
    pulse_req(1, 9, 9);
    wait_start("coal grant maze");
    step();
    pulse_req(4, 1, 1);
    pulse_req(4, 2, 2);
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    serve("coal grant draw", 1);
    repeat (8) step();
    chk("coal nstart", n_start - bs, 2);
    chk("coal op1",    op_at(bs + 1), 4);
    chk("coal x1",     x_at(bs + 1), 2);
    chk("coal y1",     y_at(bs + 1), 2);
    chk("coal ndone",  n_done - bd, 2);
    chk("coal done1",  done_at(bd + 1), 4);

    // Set/clear collision: new request on the completing index is kept.
    bs = n_start;
    bd = n_done;
    pulse_req(3, 6, 6);
    wait_start("coll grant a");
    step();
    set_req(3, 7, 8);
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    req = '0;
    chk("coll done",   {26'd0, done}, 32'h8);
    serve("coll grant b", 0);
    repeat (4) step();
    chk("coll nstart", n_start - bs, 2);
    chk("coll op1",    op_at(bs + 1), 3);
    chk("coll x1",     x_at(bs + 1), 7);
    chk("coll y1",     y_at(bs + 1), 8);
    chk("coll ndone",  n_done - bd, 2);

    // Timeout: start cycle, then TO full WAIT cycles, then the error pulse.
    bs = n_start;
    bd = n_done;
    bt = n_terr;
    pulse_req(0, 1, 2);
    wait_start("to grant");
    lat = 0;
    while (timeout_err !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("to latency", lat, TO + 1);
    chk("to busy",    {31'd0, busy}, 0);
    repeat (6) step();
    chk("to nterr",   n_terr - bt, 1);
    chk("to ndone",   n_done - bd, 0);
    chk("to nstart",  n_start - bs, 1);

    // Reset in WAIT with another request pending, then a stray engine_done.
    bs = n_start;
    bd = n_done;
    pulse_req(2, 3, 3);
    wait_start("rw grant");
    step();
    pulse_req(5, 4, 4);
    step();
    reset = 1'b1;
    #1;
    chk("rw busy",  {31'd0, busy}, 0);
    chk("rw op",    {29'd0, engine_op}, 0);
    chk("rw x",     {27'd0, engine_x}, 0);
    step();
    reset = 1'b0;
    step();
    engine_done = 1'b1;
    step();
    engine_done = 1'b0;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (engine_start !== 1'b0 || busy !== 1'b0 || done !== '0 || timeout_err !== 1'b0 ||
          engine_op !== '0 || engine_x !== '0 || engine_y !== '0) errs++;
      step();
    end
    chk("rw quiet",  errs, 0);
    chk("rw nstart", n_start - bs, 1);
    chk("rw ndone",  n_done - bd, 0);

    // Recovery after reset.
    bd = n_done;
    pulse_req(1, 5, 6);
    serve("rec grant", 0);
    chk("rec done", done_at(bd), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
